// File: rtl/alu_share_arbiter_if.sv
// Bundle of every signal exchanged between the ALU share arbiter, its two
// requesters and the shared ALU. The arbiter connects through the slave
// modport. Requesters and the ALU (or a bench standing in for them)
// connect through the master modport.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 2,
  parameter int FLAGW = 4
);
  // requester 0 operation channel
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [CTRLW-1:0] req0_ctrl;
  // requester 1 operation channel
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [CTRLW-1:0] req1_ctrl;
  // response channel: result and flags are shared, the valids are per owner
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [FLAGW-1:0] rsp_flags;
  // shared ALU connection
  logic [WIDTH-1:0] alu_srca;
  logic [WIDTH-1:0] alu_srcb;
  logic [CTRLW-1:0] alu_ctrl;
  logic [WIDTH-1:0] alu_result;
  logic [FLAGW-1:0] alu_flag;
  // status
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  rsp0_ready, rsp1_ready,
    input  alu_result, alu_flag,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
    output alu_srca, alu_srcb, alu_ctrl,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output rsp0_ready, rsp1_ready,
    output alu_result, alu_flag,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_flags,
    input  alu_srca, alu_srcb, alu_ctrl,
    input  busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one single-cycle ALU between two
// requesters with a single operation in flight. The arbiter moves through
// three states: IDLE grants a request and latches its operands, EXEC lets
// the ALU evaluate the registered operands, and RESP holds the captured
// result until the owning requester takes it.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CTRLW = 2,
  parameter int FLAGW = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_share_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // arbitration history and ownership of the operation in flight
  logic             r_last_grant;
  logic             r_owner;

  // operands held toward the ALU, and the captured response
  logic [WIDTH-1:0] r_srca;
  logic [WIDTH-1:0] r_srcb;
  logic [CTRLW-1:0] r_ctrl;
  logic [WIDTH-1:0] r_result;
  logic [FLAGW-1:0] r_flags;
  logic [1:0]       r_rsp_valid;

  // per-requester views of the interface, so the logic can be indexed
  logic [1:0]       w_req_valid;
  logic [1:0]       w_req_ready;
  logic [1:0]       w_rsp_ready;
  logic [WIDTH-1:0] w_req_a    [2];
  logic [WIDTH-1:0] w_req_b    [2];
  logic [CTRLW-1:0] w_req_ctrl [2];

  logic             w_grant_valid;
  logic             w_grant_id;
  logic             w_accept;
  logic             w_take;

  assign w_req_valid[0] = bus.req0_valid;
  assign w_req_valid[1] = bus.req1_valid;
  assign w_rsp_ready[0] = bus.rsp0_ready;
  assign w_rsp_ready[1] = bus.rsp1_ready;
  assign w_req_a[0]     = bus.req0_a;
  assign w_req_a[1]     = bus.req1_a;
  assign w_req_b[0]     = bus.req0_b;
  assign w_req_b[1]     = bus.req1_b;
  assign w_req_ctrl[0]  = bus.req0_ctrl;
  assign w_req_ctrl[1]  = bus.req1_ctrl;

  // Pick the winner among the valid requesters. A tie goes to whichever
  // requester was not granted last time.
  always_comb begin
    w_grant_valid = |w_req_valid;
    w_grant_id    = 1'b0;
    unique case (w_req_valid)
      2'b01:   w_grant_id = 1'b0;
      2'b10:   w_grant_id = 1'b1;
      2'b11:   w_grant_id = ~r_last_grant;
      default: w_grant_id = 1'b0;
    endcase
  end

  // A request is only accepted while idle. A response is only released
  // by the owner's ready. The non-owner's ready has no effect.
  assign w_accept = (r_state == S_IDLE) && w_grant_valid;
  assign w_take   = (r_state == S_RESP) && w_rsp_ready[r_owner];

  // Accept handshake per requester. At most one can be high because a
  // single grant id is decoded.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign w_req_ready[gi] = w_accept && (w_grant_id == 1'(gi));
  end

  // Choose the next state: IDLE waits for a grant, EXEC always lasts one
  // cycle, and RESP waits for the owner to take the response.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant_valid) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (w_take) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Hold the FSM state. Reset drops any operation that is in flight.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Latch the granted operands. They then stay unchanged through EXEC and
  // RESP, so the requester may change its inputs right after the accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_srca       <= '0;
      r_srcb       <= '0;
      r_ctrl       <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_srca       <= w_req_a[w_grant_id];
      r_srcb       <= w_req_b[w_grant_id];
      r_ctrl       <= w_req_ctrl[w_grant_id];
      r_owner      <= w_grant_id;
      r_last_grant <= w_grant_id;
    end
  end

  // Capture the ALU output at the end of EXEC, unchanged. Raise the
  // owner's valid and hold it until the owner takes the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result    <= '0;
      r_flags     <= '0;
      r_rsp_valid <= 2'b00;
    end else if (r_state == S_EXEC) begin
      r_result    <= bus.alu_result;
      r_flags     <= bus.alu_flag;
      r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
    end else if (w_take) begin
      r_rsp_valid <= 2'b00;
    end
  end

  assign bus.req0_ready = w_req_ready[0];
  assign bus.req1_ready = w_req_ready[1];
  assign bus.rsp0_valid = r_rsp_valid[0];
  assign bus.rsp1_valid = r_rsp_valid[1];
  assign bus.rsp_result = r_result;
  assign bus.rsp_flags  = r_flags;
  assign bus.alu_srca   = r_srca;
  assign bus.alu_srcb   = r_srcb;
  assign bus.alu_ctrl   = r_ctrl;
  assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter. A behavioural ALU drives alu_result and
// alu_flag from the arbiter's registered operands. A monitor pushes the
// expected result onto a per-requester queue when a request is accepted.
// It pops and compares the queue entry when that requester takes its
// response.
module tb_alu_share_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_share_arbiter_if #(.WIDTH(32), .CTRLW(2), .FLAGW(4)) bus_if ();

  alu_share_arbiter #(.WIDTH(32), .CTRLW(2), .FLAGW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // one comparison: count it, and report when it does not match
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference ALU: returns {N,Z,C,V,result}; C on subtract means no borrow
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        cf;
    logic        vf;
    s  = '0;
    cf = 1'b0;
    vf = 1'b0;
    case (c)
      2'b00: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        cf = s[32];
        vf = (a[31] == b[31]) && (r[31] != a[31]);
      end
      2'b01: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        cf = s[32];
        vf = (a[31] != b[31]) && (r[31] != a[31]);
      end
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'd0), cf, vf, r};
  endfunction

  // behavioural ALU driven by the arbiter's operand registers
  always_comb begin
    {bus_if.alu_flag, bus_if.alu_result} = alu_f(bus_if.alu_srca, bus_if.alu_srcb, bus_if.alu_ctrl);
  end

  // scoreboard state
  logic [35:0] q0[$];
  logic [35:0] q1[$];
  int          grant_log[$];
  int          acc_log[$];
  int          cyc     = 0;
  int          acc_cyc = 0;
  logic        prev0   = 1'b0;
  logic        prev1   = 1'b0;

  // Monitor, sampled on the falling edge. It records accepts, checks the
  // response latency and data, and checks that both response valids are
  // never high together.
  always @(negedge clk) begin
    logic [35:0] exp_v;
    cyc++;
    check("rsp_excl", 64'(bus_if.rsp0_valid & bus_if.rsp1_valid), 64'd0);
    if (reset) begin
      q0.delete();
      q1.delete();
      prev0 = 1'b0;
      prev1 = 1'b0;
    end else begin
      if (bus_if.req0_valid && bus_if.req0_ready) begin
        q0.push_back(alu_f(bus_if.req0_a, bus_if.req0_b, bus_if.req0_ctrl));
        grant_log.push_back(0);
        acc_log.push_back(cyc);
        acc_cyc = cyc;
      end
      if (bus_if.req1_valid && bus_if.req1_ready) begin
        q1.push_back(alu_f(bus_if.req1_a, bus_if.req1_b, bus_if.req1_ctrl));
        grant_log.push_back(1);
        acc_log.push_back(cyc);
        acc_cyc = cyc;
      end
      if (bus_if.rsp0_valid && !prev0) check("rsp0_latency", 64'(cyc - acc_cyc), 64'd2);
      if (bus_if.rsp1_valid && !prev1) check("rsp1_latency", 64'(cyc - acc_cyc), 64'd2);
      if (bus_if.rsp0_valid && bus_if.rsp0_ready) begin
        if (q0.size() == 0) check("rsp0_unexpected", 64'd1, 64'd0);
        else begin
          exp_v = q0.pop_front();
          $display("rsp0 taken: result=0x%08h flags=%b", bus_if.rsp_result, bus_if.rsp_flags);
          check("rsp0_data", 64'({bus_if.rsp_flags, bus_if.rsp_result}), 64'(exp_v));
        end
      end
      if (bus_if.rsp1_valid && bus_if.rsp1_ready) begin
        if (q1.size() == 0) check("rsp1_unexpected", 64'd1, 64'd0);
        else begin
          exp_v = q1.pop_front();
          $display("rsp1 taken: result=0x%08h flags=%b", bus_if.rsp_result, bus_if.rsp_flags);
          check("rsp1_data", 64'({bus_if.rsp_flags, bus_if.rsp_result}), 64'(exp_v));
        end
      end
      prev0 = bus_if.rsp0_valid;
      prev1 = bus_if.rsp1_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int n, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] c);
    if (n == 0) begin
      bus_if.req0_valid = v; bus_if.req0_a = a; bus_if.req0_b = b; bus_if.req0_ctrl = c;
    end else begin
      bus_if.req1_valid = v; bus_if.req1_a = a; bus_if.req1_b = b; bus_if.req1_ctrl = c;
    end
  endtask

  task automatic set_valid(input int n, input logic v);
    if (n == 0) bus_if.req0_valid = v;
    else        bus_if.req1_valid = v;
  endtask

  // Raise a request, wait (bounded) for its accept, then drop valid.
  task automatic do_req(input int n, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c);
    logic got;
    got = 1'b0;
    drive_req(n, 1'b1, a, b, c);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (n == 0) ? bus_if.req0_ready : bus_if.req1_ready;
    end
    check("accept_wait", 64'(got), 64'd1);
    tick();
    set_valid(n, 1'b0);
  endtask

  // Wait (bounded) until the arbiter is idle with no pending response.
  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 30 && !idle; i++) begin
      @(negedge clk);
      idle = !bus_if.busy && !bus_if.rsp0_valid && !bus_if.rsp1_valid;
    end
    check("idle_wait", 64'(idle), 64'd1);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp0_valid"}, 64'(bus_if.rsp0_valid), 64'd0);
    check({tag, "_rsp1_valid"}, 64'(bus_if.rsp1_valid), 64'd0);
    check({tag, "_result"},     64'(bus_if.rsp_result), 64'd0);
    check({tag, "_flags"},      64'(bus_if.rsp_flags),  64'd0);
    check({tag, "_srca"},       64'(bus_if.alu_srca),   64'd0);
    check({tag, "_srcb"},       64'(bus_if.alu_srcb),   64'd0);
    check({tag, "_ctrl"},       64'(bus_if.alu_ctrl),   64'd0);
    check({tag, "_busy"},       64'(bus_if.busy),       64'd0);
  endtask

  initial begin
    logic seen;
    bus_if.req0_valid = 1'b0; bus_if.req0_a = '0; bus_if.req0_b = '0; bus_if.req0_ctrl = '0;
    bus_if.req1_valid = 1'b0; bus_if.req1_a = '0; bus_if.req1_b = '0; bus_if.req1_ctrl = '0;
    bus_if.rsp0_ready = 1'b1;
    bus_if.rsp1_ready = 1'b1;

    // reset for two cycles, then check the idle reset state
    tick();
    tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");
    check("post_reset_ready0", 64'(bus_if.req0_ready), 64'd0);
    tick();

    // single add, then subtracts that produce negative and zero results
    do_req(0, 32'd4, 32'd5, 2'b00);
    wait_idle();
    do_req(1, 32'd4, 32'd5, 2'b01);
    wait_idle();
    do_req(1, 32'd5, 32'd5, 2'b01);
    wait_idle();
    do_req(0, 32'h8000_0000, 32'h8000_0000, 2'b00);
    wait_idle();

    // tie after reset: alternate 0,1,0,1 with one accept every 3 cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    grant_log.delete();
    acc_log.delete();
    drive_req(0, 1'b1, 32'hF0, 32'h3C, 2'b10);
    drive_req(1, 1'b1, 32'hF0, 32'h0F, 2'b11);
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) @(negedge clk);
    tick();
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    wait_idle();
    check("rr_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("rr_order", 64'(grant_log[i]), 64'(i % 2));
    for (int i = 0; i < 3 && i + 1 < acc_log.size(); i++)
      check("rr_interval", 64'(acc_log[i+1] - acc_log[i]), 64'd3);

    // backpressure: response 0 held for five cycles while requester 1 waits
    bus_if.rsp0_ready = 1'b0;
    drive_req(1, 1'b1, 32'd7, 32'd8, 2'b00);
    drive_req(0, 1'b1, 32'd1, 32'd2, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus_if.req0_ready;
    end
    check("bp_accept0", 64'(seen), 64'd1);
    tick();
    set_valid(0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp0_valid", 64'(bus_if.rsp0_valid), 64'd1);
      check("bp_result",     64'(bus_if.rsp_result), 64'd3);
      check("bp_busy",       64'(bus_if.busy),       64'd1);
      check("bp_ready1",     64'(bus_if.req1_ready), 64'd0);
    end
    tick();
    bus_if.rsp0_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_grant1_next", 64'(bus_if.req1_ready), 64'd1);
    tick();
    set_valid(1, 1'b0);
    wait_idle();

    // reset during EXEC drops the operation and restores the tie priority
    drive_req(0, 1'b1, 32'h11, 32'h22, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus_if.req0_ready;
    end
    check("rst_accept0", 64'(seen), 64'd1);
    tick();
    set_valid(0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_reset_no_rsp0", 64'(bus_if.rsp0_valid), 64'd0);
    end
    tick();
    grant_log.delete();
    drive_req(0, 1'b1, 32'h6, 32'h3, 2'b01);
    drive_req(1, 1'b1, 32'h6, 32'h3, 2'b10);
    for (int i = 0; i < 20 && grant_log.size() < 1; i++) @(negedge clk);
    tick();
    set_valid(0, 1'b0);
    set_valid(1, 1'b0);
    wait_idle();
    check("mid_reset_tie", 64'((grant_log.size() > 0) ? grant_log[0] : 9), 64'd0);

    // operands changed right after the accept are ignored
    drive_req(0, 1'b1, 32'h100, 32'h23, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus_if.req0_ready;
    end
    check("hold_accept0", 64'(seen), 64'd1);
    tick();
    drive_req(0, 1'b0, 32'hDEAD, 32'hBEEF, 2'b11);
    @(negedge clk);
    check("hold_srca_exec", 64'(bus_if.alu_srca), 64'h100);
    @(negedge clk);
    check("hold_srca_resp", 64'(bus_if.alu_srca), 64'h100);
    check("hold_ctrl_resp", 64'(bus_if.alu_ctrl), 64'd0);
    wait_idle();

    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
